div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multi-cycle 32-bit signed/unsigned radix-2 divider for DIV/DIVU.
- Sits in the EX stage. Its stall request feeds the pipeline controller's stop_from_ex input.
- EX holds the operands and start until the block asserts ready_o. The quotient/remainder pair is then written to HI/LO.
- A controller flush aborts an in-flight division through annul_i.

Parameters:
- WIDTH, 32, operand width; quotient and remainder each WIDTH bits.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- start_i  input  1  division request; held high by EX until ready_o is seen.
- signed_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start_i in IDLE.
- opdata1_i  input  WIDTH  dividend; sampled in IDLE.
- opdata2_i  input  WIDTH  divisor; sampled in IDLE.
- annul_i  input  1  abort (controller flush); highest priority after rst.
- result_o  output  2*WIDTH  {remainder, quotient}; valid only while ready_o = 1.
- ready_o  output  1  result valid.
- stop_o  output  1  stall request to the controller (drives stop_from_ex).

Behaviour:
- States: IDLE, BYZERO, ON, DONE.
- Internal registers: state, cnt (CNT_W bits), 2*WIDTH+1-bit partial-remainder/quotient shift register, sign_q, sign_r.
- Reset (rst high, asynchronous): state = IDLE, cnt = 0, all datapath registers cleared, result_o = 0, ready_o = 0. stop_o is combinationally 0 while rst is high.
- IDLE:
  - start_i = 0 or annul_i = 1: remain in IDLE.
  - start_i = 1 and opdata2_i = 0: go to BYZERO.
  - Otherwise: latch operands and go to ON with cnt = 0.
  - If signed_i = 1, latch absolute values and record sign_q = op1[MSB] ^ op2[MSB] and sign_r = op1[MSB].
  - If signed_i = 0, both sign flags are 0.
- ON:
  - One restoring step per cycle: shift left 1, trial-subtract the divisor from the upper half.
  - If the trial result is non-negative, keep it and set quotient LSB = 1; otherwise restore and set LSB = 0.
  - cnt increments each cycle. The step at which cnt reaches WIDTH-1 is the last; the next state is DONE.
- DONE:
  - result_o = {sign-corrected remainder, sign-corrected quotient}.
  - Quotient is two's-complement-negated if sign_q = 1; remainder is negated if sign_r = 1.
  - ready_o = 1.
  - Stay in DONE while start_i = 1. Go to IDLE when start_i = 0; ready_o and result_o clear on that edge.
- BYZERO: one cycle, then DONE with result_o = 0 (quotient 0, remainder 0). Division by zero is architecturally UNPREDICTABLE; 0 is the defined value.
- annul_i = 1 in any state: next state is IDLE, ready_o = 0, result_o = 0. Annul overrides completion on the same edge.
- stop_o (combinational) = start_i & ~ready_o & ~annul_i.
  - High from the first cycle start_i is seen until the cycle ready_o is high.
  - Never high during a flush, so flushes are never blocked.
- Latency, with the first start_i cycle as cycle 0:
  - Normal path: ready_o is high in cycle WIDTH+1 (cycle 33 for WIDTH = 32).
  - Divide by zero: ready_o is high in cycle 2.
- start_i held high through DONE does not restart a division. A new division requires start_i low for at least one cycle (the return to IDLE).
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0. This falls out of the magnitude path with no special case.
- Operand changes while in ON or DONE are ignored.

Test Plan:
- Unsigned 100 / 7, start_i held → stop_o = 1 in cycles 0–32; ready_o = 1 first in cycle 33; result_o = {0x00000002, 0x0000000E}. Drop start_i → IDLE next cycle, ready_o = 0.
- Signed −7 / 2 (0xFFFFFFF9 / 0x00000002) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7 / −2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- Divisor 0 (DIVU 5 / 0) → BYZERO, ready_o = 1 in cycle 2, result_o = 0, stop_o = 0 in that cycle.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0; and unsigned 0xFFFFFFFF / 1 → quotient 0xFFFFFFFF, remainder 0.
- annul_i pulsed in cycle 10 of an active division → stop_o = 0 in that cycle, state IDLE next cycle, ready_o never asserted. A new request started afterwards completes correctly with full latency.
- rst asserted asynchronously mid-ON (between clock edges) → ready_o = 0, result_o = 0, stop_o = 0 immediately. After rst is released, a fresh 100 / 7 gives the correct result in cycle 33.

Source files
------------

// File: rtl/div_unit_if.sv
// div_unit_if: request/response bundle between the EX stage and the divider.
//   master (EX side): drives start_i, signed_i, opdata1_i, opdata2_i, annul_i;
//                     receives result_o, ready_o, stop_o.
//   slave (divider):  the mirror image.
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic               start_i;
  logic               signed_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;
  logic               stop_o;

  modport master (
    output start_i, signed_i, opdata1_i, opdata2_i, annul_i,
    input  result_o, ready_o, stop_o
  );

  modport slave (
    input  start_i, signed_i, opdata1_i, opdata2_i, annul_i,
    output result_o, ready_o, stop_o
  );
endinterface

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU.
//   clk, rst       : clock and asynchronous active-high reset
//   bus (slave)    : start_i/signed_i/opdata1_i/opdata2_i request held by EX,
//                    annul_i flush, result_o = {remainder, quotient} valid
//                    while ready_o, stop_o = stall request to the controller.
// Signed operands are divided as magnitudes; the quotient takes the XOR of
// the operand signs and the remainder takes the dividend's sign.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BYZERO = 2'd1,
    ON     = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  state_t             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [2*WIDTH:0]   rem_quo_r;   // {partial remainder, dividend/quotient}
  logic [WIDTH-1:0]   divisor_r;   // divisor magnitude
  logic               sign_q_r;
  logic               sign_r_r;
  logic [2*WIDTH-1:0] result_r;
  logic               ready_r;

  logic [WIDTH+1:0]   trial_s;
  logic [2*WIDTH:0]   step_s;

  // Conditional two's-complement negation (used for magnitude and sign fix-up).
  function automatic logic [WIDTH-1:0] neg_cond(input logic [WIDTH-1:0] v,
                                                input logic en);
    logic [WIDTH-1:0] r;
    if (en) begin
      r = ~v + WIDTH'(1'b1);
    end else begin
      r = v;
    end
    return r;
  endfunction

  // One restoring step: the shifted upper half minus the divisor.
  always_comb begin
    trial_s = rem_quo_r[2*WIDTH:WIDTH-1] - {2'b00, divisor_r};
    step_s  = {rem_quo_r[2*WIDTH-1:0], 1'b0};
    if (!trial_s[WIDTH+1]) begin
      step_s = {trial_s[WIDTH:0], rem_quo_r[WIDTH-2:0], 1'b1};
    end else begin
      step_s = {rem_quo_r[2*WIDTH-1:0], 1'b0};
    end
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      rem_quo_r <= {(2*WIDTH+1){1'b0}};
      divisor_r <= {WIDTH{1'b0}};
      sign_q_r  <= 1'b0;
      sign_r_r  <= 1'b0;
      result_r  <= {(2*WIDTH){1'b0}};
      ready_r   <= 1'b0;
    end else if (bus.annul_i) begin
      // A flush wins over everything, including a completion on this edge.
      state_r  <= IDLE;
      result_r <= {(2*WIDTH){1'b0}};
      ready_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start_i) begin
            if (bus.opdata2_i == {WIDTH{1'b0}}) begin
              state_r <= BYZERO;
            end else begin
              rem_quo_r <= {{(WIDTH+1){1'b0}},
                            neg_cond(bus.opdata1_i, bus.signed_i & bus.opdata1_i[WIDTH-1])};
              divisor_r <= neg_cond(bus.opdata2_i, bus.signed_i & bus.opdata2_i[WIDTH-1]);
              sign_q_r  <= bus.signed_i & (bus.opdata1_i[WIDTH-1] ^ bus.opdata2_i[WIDTH-1]);
              sign_r_r  <= bus.signed_i & bus.opdata1_i[WIDTH-1];
              cnt_r     <= {CNT_W{1'b0}};
              state_r   <= ON;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        BYZERO: begin
          state_r  <= DONE;
          result_r <= {(2*WIDTH){1'b0}};
          ready_r  <= 1'b1;
        end
        ON: begin
          rem_quo_r <= step_s;
          cnt_r     <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            state_r  <= DONE;
            ready_r  <= 1'b1;
            result_r <= {neg_cond(step_s[2*WIDTH-1:WIDTH], sign_r_r),
                         neg_cond(step_s[WIDTH-1:0], sign_q_r)};
          end else begin
            state_r <= ON;
          end
        end
        DONE: begin
          // start_i still high means EX has not consumed the result yet.
          if (!bus.start_i) begin
            state_r  <= IDLE;
            result_r <= {(2*WIDTH){1'b0}};
            ready_r  <= 1'b0;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r  <= IDLE;
          result_r <= {(2*WIDTH){1'b0}};
          ready_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.result_o = result_r;
  assign bus.ready_o  = ready_r;
  // Stall is gated by annul_i so a flush can always proceed.
  assign bus.stop_o   = bus.start_i & ~ready_r & ~bus.annul_i & ~rst;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_unit_if #(.WIDTH(32)) dif ();

  div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  int passed = 0;
  int total  = 0;
  logic [63:0] exp_q[$];

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic s);
    logic signed [31:0] sa, sb, sq, sr;
    logic [31:0] q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = a; sb = b;
      sq = sa / sb; sr = sa % sb;
      q = sq; r = sr;
    end else begin
      q = a / b; r = a % b;
    end
    return {r, q};
  endfunction

  // Drives one request and holds start_i through one extra DONE cycle; no checks.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output int lat, output int stop_bad, output logic [63:0] res,
                       output logic held_rdy, output logic [63:0] held_res,
                       output logic after_rdy);
    lat = -1; stop_bad = 0; res = 64'd0;
    @(posedge clk); #1;
    dif.start_i = 1'b1; dif.signed_i = s; dif.opdata1_i = a; dif.opdata2_i = b;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (dif.ready_o === 1'b1) begin
        lat = c; res = dif.result_o;
        if (dif.stop_o !== 1'b0) stop_bad++;
        break;
      end
      if (dif.stop_o !== 1'b1) stop_bad++;
      @(posedge clk); #1;
      dif.opdata1_i = $urandom; dif.opdata2_i = $urandom; dif.signed_i = ~s;
    end
    @(posedge clk); #1;
    @(negedge clk);
    held_rdy = dif.ready_o; held_res = dif.result_o;
    @(posedge clk); #1;
    dif.start_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    after_rdy = dif.ready_o;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    dif.start_i = 1'b1; dif.signed_i = 1'b0; dif.annul_i = 1'b0;
    dif.opdata1_i = 32'd100; dif.opdata2_i = 32'd7;
    repeat (2) @(negedge clk);
    total++; if (dif.ready_o !== 1'b0) $display("FAIL reset_ready: got %b expected 0", dif.ready_o); else passed++;
    total++; if (dif.result_o !== 64'd0) $display("FAIL reset_result: got %h expected 0", dif.result_o); else passed++;
    total++; if (dif.stop_o !== 1'b0) $display("FAIL reset_stop: got %b expected 0", dif.stop_o); else passed++;
    dif.start_i = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_unsigned;
    int lat, sb; logic [63:0] res, hres, e; logic hr, ar;
    exp_q.push_back({32'h00000002, 32'h0000000E});
    issue(32'd100, 32'd7, 1'b0, lat, sb, res, hr, hres, ar);
    e = exp_q.pop_front();
    total++; if (lat !== 33) $display("FAIL udiv_latency: got %0d expected 33", lat); else passed++;
    total++; if (sb !== 0) $display("FAIL udiv_stop: %0d bad stop cycles expected 0", sb); else passed++;
    total++; if (res !== e) $display("FAIL udiv_result: got %h expected %h", res, e); else passed++;
    total++; if (hr !== 1'b1) $display("FAIL udiv_hold_ready: got %b expected 1", hr); else passed++;
    total++; if (hres !== e) $display("FAIL udiv_hold_result: got %h expected %h", hres, e); else passed++;
    total++; if (ar !== 1'b0) $display("FAIL udiv_release: ready got %b expected 0", ar); else passed++;
  endtask

  task automatic test_signed;
    logic [31:0] ta [4] = '{32'hFFFFFFF9, 32'h00000007, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] tb [4] = '{32'h00000002, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000001};
    logic        ts [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [63:0] te [4] = '{{32'hFFFFFFFF, 32'hFFFFFFFD}, {32'h00000001, 32'hFFFFFFFD},
                            {32'h00000000, 32'h80000000}, {32'h00000000, 32'hFFFFFFFF}};
    int lat, sb; logic [63:0] res, hres, e; logic hr, ar;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(te[i]);
      issue(ta[i], tb[i], ts[i], lat, sb, res, hr, hres, ar);
      e = exp_q.pop_front();
      total++; if (res !== e) $display("FAIL sdiv_result[%0d]: got %h expected %h", i, res, e); else passed++;
      total++; if (lat !== 33) $display("FAIL sdiv_latency[%0d]: got %0d expected 33", i, lat); else passed++;
    end
  endtask

  task automatic test_byzero;
    int lat, sb; logic [63:0] res, hres, e; logic hr, ar;
    exp_q.push_back(64'd0);
    issue(32'd5, 32'd0, 1'b0, lat, sb, res, hr, hres, ar);
    e = exp_q.pop_front();
    total++; if (lat !== 2) $display("FAIL byzero_latency: got %0d expected 2", lat); else passed++;
    total++; if (sb !== 0) $display("FAIL byzero_stop: %0d bad stop cycles expected 0", sb); else passed++;
    total++; if (res !== e) $display("FAIL byzero_result: got %h expected %h", res, e); else passed++;
    total++; if (ar !== 1'b0) $display("FAIL byzero_release: ready got %b expected 0", ar); else passed++;
  endtask

  task automatic test_annul;
    int saw = 0;
    int lat, sb; logic [63:0] res, hres, e; logic hr, ar;
    @(posedge clk); #1;
    dif.start_i = 1'b1; dif.signed_i = 1'b0; dif.opdata1_i = 32'd1000; dif.opdata2_i = 32'd3;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (dif.ready_o === 1'b1) saw++;
      @(posedge clk); #1;
    end
    dif.annul_i = 1'b1;
    @(negedge clk);
    total++; if (dif.stop_o !== 1'b0) $display("FAIL annul_stop: got %b expected 0", dif.stop_o); else passed++;
    @(posedge clk); #1;
    dif.annul_i = 1'b0; dif.start_i = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (dif.ready_o === 1'b1) saw++;
    end
    total++; if (saw !== 0) $display("FAIL annul_no_ready: ready seen %0d cycles expected 0", saw); else passed++;
    exp_q.push_back(model(32'd100, 32'd7, 1'b0));
    issue(32'd100, 32'd7, 1'b0, lat, sb, res, hr, hres, ar);
    e = exp_q.pop_front();
    total++; if (lat !== 33) $display("FAIL annul_retry_latency: got %0d expected 33", lat); else passed++;
    total++; if (res !== e) $display("FAIL annul_retry_result: got %h expected %h", res, e); else passed++;
  endtask

  task automatic test_async_reset;
    int lat, sb; logic [63:0] res, hres, e; logic hr, ar;
    int waited = 0;
    // Reset mid-ON, between clock edges.
    @(posedge clk); #1;
    dif.start_i = 1'b1; dif.signed_i = 1'b0; dif.opdata1_i = 32'd100; dif.opdata2_i = 32'd7;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    total++; if (dif.ready_o !== 1'b0) $display("FAIL arst_on_ready: got %b expected 0", dif.ready_o); else passed++;
    total++; if (dif.result_o !== 64'd0) $display("FAIL arst_on_result: got %h expected 0", dif.result_o); else passed++;
    total++; if (dif.stop_o !== 1'b0) $display("FAIL arst_on_stop: got %b expected 0", dif.stop_o); else passed++;
    @(negedge clk);
    rst = 1'b0; dif.start_i = 1'b0;
    // Reset while a result is being held in DONE.
    @(posedge clk); #1;
    dif.start_i = 1'b1;
    while (dif.ready_o !== 1'b1 && waited < 60) begin
      @(posedge clk); #1; waited++;
    end
    total++; if (waited >= 60) $display("FAIL arst_done_wait: waited %0d cycles limit 60", waited); else passed++;
    #2 rst = 1'b1;
    #1;
    total++; if (dif.ready_o !== 1'b0) $display("FAIL arst_done_ready: got %b expected 0", dif.ready_o); else passed++;
    total++; if (dif.result_o !== 64'd0) $display("FAIL arst_done_result: got %h expected 0", dif.result_o); else passed++;
    @(negedge clk);
    rst = 1'b0; dif.start_i = 1'b0;
    exp_q.push_back({32'h00000002, 32'h0000000E});
    issue(32'd100, 32'd7, 1'b0, lat, sb, res, hr, hres, ar);
    e = exp_q.pop_front();
    total++; if (lat !== 33) $display("FAIL arst_retry_latency: got %0d expected 33", lat); else passed++;
    total++; if (res !== e) $display("FAIL arst_retry_result: got %h expected %h", res, e); else passed++;
  endtask

  task automatic test_back_to_back;
    int lat, sb; logic [63:0] res, hres, e; logic hr, ar;
    logic [31:0] a, b; logic s;
    for (int i = 0; i < 6; i++) begin
      a = $urandom; b = $urandom >> (i * 5); s = i[0];
      if (b == 32'd0) b = 32'd9;
      if (s && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd3;
      exp_q.push_back(model(a, b, s));
      issue(a, b, s, lat, sb, res, hr, hres, ar);
      e = exp_q.pop_front();
      total++;
      if (res !== e || lat !== 33 || sb !== 0)
        $display("FAIL b2b[%0d] %h/%h s=%b: got %h lat %0d stopbad %0d expected %h lat 33 stopbad 0",
                 i, a, b, s, res, lat, sb, e);
      else passed++;
    end
    total++; if (exp_q.size() !== 0) $display("FAIL scoreboard_empty: got %0d entries expected 0", exp_q.size()); else passed++;
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_byzero();
    test_annul();
    test_async_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
